id_ex_stage: RTL
================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have the following ports (name, direction, width, meaning):
REQ-002 clk_i  in  1  single clock; all state updates on rising edge.
REQ-003 rst_i  in  1  synchronous, active-low reset.
REQ-004 MemStall_i  in  1  downstream memory stall; freezes the stage.
REQ-005 Flush_i  in  1  taken branch resolved in ID; the ID instruction is squashed.
REQ-006 ID_valid_i  in  1  the ID slot holds a real instruction.
REQ-007 ID_Rs1_i, ID_Rs2_i, ID_Rd_i  in  5 each  register indices from decode.
REQ-008 ID_RS1data_i, ID_RS2data_i, ID_Imm_i  in  32 each  register-file read data and immediate.
REQ-009 ID_funct_i  in  10  {funct7, funct3}.
REQ-010 ID_ALUOp_i  in  2, plus 1-bit inputs ID_ALUSrc_i, ID_RegWrite_i, ID_MemtoReg_i, ID_MemRead_i, ID_MemWrite_i: decode control.
REQ-011 EX_* outputs, one per ID_* input above, same width: registered EX-stage copies; EX_Rs1_o/EX_Rs2_o feed the forwarding unit.
REQ-012 Stall_o  out  1  hold the PC and the IF/ID register this cycle.
REQ-013 BubbleCnt_o  out  16  count of inserted load-use bubbles, saturating.

Function
REQ-014 Hazard (combinational) SHALL be EX_valid_o & EX_MemRead_o & (EX_Rd_o != 0) & ID_valid_i & (EX_Rd_o == ID_Rs1_i | EX_Rd_o == ID_Rs2_i).
REQ-015 Stall_o SHALL equal MemStall_i | (Hazard & ~Flush_i & state==RUN); it is combinational with zero latency.
REQ-016 FSM states: RUN and BUBBLE. RUN->BUBBLE when Hazard & ~Flush_i & ~MemStall_i. BUBBLE->RUN on the next non-MemStall cycle. The FSM holds while MemStall_i=1.
REQ-017 Precedence, highest first: MemStall_i (all EX registers and the FSM hold; the counter holds); Flush_i (load a bubble); Hazard in RUN (load a bubble); otherwise load the ID values.
REQ-018 Bubble load SHALL clear EX_valid_o, EX_RegWrite_o, EX_MemRead_o, EX_MemWrite_o, EX_MemtoReg_o, EX_ALUSrc_o, EX_ALUOp_o and EX_Rd_o, and SHALL set EX_Rs1_o and EX_Rs2_o to 0. Data and immediate fields SHALL take don't-care values, and the bench SHALL NOT check them.
REQ-019 In BUBBLE state, Hazard SHALL NOT cause a second bubble; the stalled instruction loads normally. At most one consecutive bubble is inserted per load-use pair.
REQ-020 Normal load latency SHALL be exactly 1 cycle from ID_* to EX_*.
REQ-021 BubbleCnt_o SHALL increment by 1 on each hazard-bubble load. Flush bubbles SHALL NOT be counted. The counter saturates at 16'hFFFF and does not wrap.
REQ-022 When Flush_i and Hazard occur in the same cycle, the stage SHALL load one bubble, Stall_o=0, the counter SHALL NOT change, and the FSM stays in RUN.
REQ-023 When Hazard and MemStall_i occur in the same cycle, the stage SHALL hold with Stall_o=1. The hazard is re-evaluated once MemStall_i falls.

Reset
REQ-024 When rst_i=0 at a rising edge, the stage SHALL clear all EX_* outputs to 0, set the FSM to RUN, and set BubbleCnt_o to 0. Reset overrides MemStall_i and Flush_i.
REQ-025 Reset mid-stall SHALL abandon the bubble. The first cycle after reset sees Stall_o = MemStall_i only.

Structure
REQ-026 A shared package SHALL hold the ALUOp encodings, the state enum {RUN, BUBBLE}, a packed control-bundle typedef (ALUOp, ALUSrc, RegWrite, MemtoReg, MemRead, MemWrite, valid) and a BUBBLE_CTRL all-zero constant.
REQ-027 The Hazard equation SHALL be a combinational sub-module hazard_detect. The FSM, pipeline registers and counter SHALL be in id_ex_stage.

Verification
REQ-028 Load-use: cycle 0 EX holds lw x5 (MemRead=1, Rd=5) and ID holds add x6,x5,x1. Expected: Stall_o=1 in cycle 0; cycle 1 EX is a bubble; cycle 2 EX_Rs1_o=5, EX_Rd_o=6; BubbleCnt_o=1.
REQ-029 No hazard on x0: EX holds lw x0 and ID reads x0. Expected: Stall_o=0, no bubble, counter stays 0.
REQ-030 Flush with hazard: same setup as REQ-028 plus Flush_i=1. Expected: Stall_o=0, next EX is a bubble, counter 0, FSM in RUN.
REQ-031 MemStall: MemStall_i=1 for 3 cycles during a hazard. Expected: EX outputs are constant, Stall_o=1 throughout, and exactly one bubble follows release.
REQ-032 Saturation and reset: preload the counter to 16'hFFFE and cause 3 hazards. Expected: counter reads FFFF. Then rst_i=0 for 1 cycle. Expected: all EX_* outputs 0, counter 0.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared types for the ID/EX pipeline stage: ALU op codes, stage FSM states and
// the control bundle that the bubble logic clears as a unit.
package id_ex_stage_pkg;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } state_t;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       valid;
  } ctrl_t;

  localparam ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detector: a load in EX writes a register the ID instruction reads.
// Purely combinational, zero latency; no flow control of its own.
module hazard_detect (
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  output logic       hazard
);

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign hazard = ex_valid & ex_mem_read & (ex_rd != 5'd0) & id_valid &
                  ((ex_rd == id_rs1) | (ex_rd == id_rs2));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble FSM and saturating bubble counter.
// Latency 1 cycle ID->EX; MemStall_i freezes everything, Stall_o holds PC and IF/ID.
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemStall_i,
  input  logic        Flush_i,
  input  logic        ID_valid_i,
  input  logic [4:0]  ID_Rs1_i,
  input  logic [4:0]  ID_Rs2_i,
  input  logic [4:0]  ID_Rd_i,
  input  logic [31:0] ID_RS1data_i,
  input  logic [31:0] ID_RS2data_i,
  input  logic [31:0] ID_Imm_i,
  input  logic [9:0]  ID_funct_i,
  input  logic [1:0]  ID_ALUOp_i,
  input  logic        ID_ALUSrc_i,
  input  logic        ID_RegWrite_i,
  input  logic        ID_MemtoReg_i,
  input  logic        ID_MemRead_i,
  input  logic        ID_MemWrite_i,
  output logic        EX_valid_o,
  output logic [4:0]  EX_Rs1_o,
  output logic [4:0]  EX_Rs2_o,
  output logic [4:0]  EX_Rd_o,
  output logic [31:0] EX_RS1data_o,
  output logic [31:0] EX_RS2data_o,
  output logic [31:0] EX_Imm_o,
  output logic [9:0]  EX_funct_o,
  output logic [1:0]  EX_ALUOp_o,
  output logic        EX_ALUSrc_o,
  output logic        EX_RegWrite_o,
  output logic        EX_MemtoReg_o,
  output logic        EX_MemRead_o,
  output logic        EX_MemWrite_o,
  output logic        Stall_o,
  output logic [15:0] BubbleCnt_o
);

  ctrl_t       ctrl_q;
  ctrl_t       id_ctrl;
  state_t      state_q;
  logic [4:0]  rs1_q, rs2_q, rd_q;
  logic [31:0] rs1data_q, rs2data_q, imm_q;
  logic [9:0]  funct_q;
  logic [15:0] bubble_cnt;
  logic        hazard;
  logic        hazard_bubble;

  always_comb begin
    id_ctrl            = BUBBLE_CTRL;
    id_ctrl.alu_op     = ID_ALUOp_i;
    id_ctrl.alu_src    = ID_ALUSrc_i;
    id_ctrl.reg_write  = ID_RegWrite_i;
    id_ctrl.mem_to_reg = ID_MemtoReg_i;
    id_ctrl.mem_read   = ID_MemRead_i;
    id_ctrl.mem_write  = ID_MemWrite_i;
    id_ctrl.valid      = ID_valid_i;
  end

  hazard_detect u_hazard_detect (
    .ex_valid    (ctrl_q.valid),
    .ex_mem_read (ctrl_q.mem_read),
    .ex_rd       (rd_q),
    .id_valid    (ID_valid_i),
    .id_rs1      (ID_Rs1_i),
    .id_rs2      (ID_Rs2_i),
    .hazard      (hazard)
  );

  // A flush already squashes the ID instruction, so the hazard bubble is moot then.
  assign hazard_bubble = hazard & ~Flush_i & (state_q == RUN);
  assign Stall_o       = MemStall_i | hazard_bubble;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ctrl_q     <= BUBBLE_CTRL;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      rs1data_q  <= '0;
      rs2data_q  <= '0;
      imm_q      <= '0;
      funct_q    <= '0;
      state_q    <= RUN;
      bubble_cnt <= '0;
    end else if (!MemStall_i) begin
      rs1data_q <= ID_RS1data_i;
      rs2data_q <= ID_RS2data_i;
      imm_q     <= ID_Imm_i;
      funct_q   <= ID_funct_i;
      if (Flush_i || hazard_bubble) begin
        ctrl_q <= BUBBLE_CTRL;
        rs1_q  <= '0;
        rs2_q  <= '0;
        rd_q   <= '0;
      end else begin
        ctrl_q <= id_ctrl;
        rs1_q  <= ID_Rs1_i;
        rs2_q  <= ID_Rs2_i;
        rd_q   <= ID_Rd_i;
      end
      state_q <= hazard_bubble ? BUBBLE : RUN;
      if (hazard_bubble && (bubble_cnt != 16'hFFFF)) begin
        bubble_cnt <= bubble_cnt + 16'd1;
      end
    end
  end

  assign EX_valid_o    = ctrl_q.valid;
  assign EX_ALUOp_o    = ctrl_q.alu_op;
  assign EX_ALUSrc_o   = ctrl_q.alu_src;
  assign EX_RegWrite_o = ctrl_q.reg_write;
  assign EX_MemtoReg_o = ctrl_q.mem_to_reg;
  assign EX_MemRead_o  = ctrl_q.mem_read;
  assign EX_MemWrite_o = ctrl_q.mem_write;
  assign EX_Rs1_o      = rs1_q;
  assign EX_Rs2_o      = rs2_q;
  assign EX_Rd_o       = rd_q;
  assign EX_RS1data_o  = rs1data_q;
  assign EX_RS2data_o  = rs2data_q;
  assign EX_Imm_o      = imm_q;
  assign EX_funct_o    = funct_q;
  assign BubbleCnt_o   = bubble_cnt;

endmodule
